control_fsm: RTL and testbench

Multi-cycle control unit sitting directly upstream of the `datapath` block. Accepts one 32-bit RV32I-subset instruction at a time from the fetch stage over a valid/ready handshake, latches it, decodes it, and sequences the datapath strobes `ctrl0`–`ctrl4`, `ALUOp`, and the register addresses through DECODE/EXEC/MEM/WB states. Reports completion, branch outcome and illegal encodings back to the PC logic.

---
 rtl/ctrl_pkg.sv | 29 ++
 rtl/control_fsm_if.sv | 33 +++
 rtl/alu_decoder.sv | 33 +++
 rtl/control_fsm.sv | 110 +++++++++++
 tb/tb_control_fsm.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/ctrl_pkg.sv
// ctrl_pkg: opcodes, ALU op and state encodings, ctrl strobe bit indices for control_fsm.
package ctrl_pkg;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam int CTRL_REG_WRITE  = 0;
  localparam int CTRL_ALU_SRC    = 1;
  localparam int CTRL_IMM_EN     = 2;
  localparam int CTRL_MEM_TO_REG = 3;
  localparam int CTRL_MEM_WRITE  = 4;
  typedef enum logic [2:0] {
    ALU_ADD = 3'b000, ALU_SUB = 3'b001, ALU_AND = 3'b010, ALU_OR  = 3'b011,
    ALU_XOR = 3'b100, ALU_SLT = 3'b101, ALU_SLL = 3'b110, ALU_SRL = 3'b111
  } alu_op_e;
  typedef enum logic [2:0] {S_IDLE, S_DECODE, S_EXEC, S_MEM, S_WB} state_e;
  function automatic alu_op_e f3_to_alu_op(input logic [2:0] f3);
    case (f3)
      3'b111:  return ALU_AND;
      3'b110:  return ALU_OR;
      3'b100:  return ALU_XOR;
      3'b010:  return ALU_SLT;
      3'b001:  return ALU_SLL;
      3'b101:  return ALU_SRL;
      default: return ALU_ADD;
    endcase
  endfunction
endpackage

// File: rtl/control_fsm_if.sv
// control_fsm_if: fetch handshake, datapath strobes and PC feedback of control_fsm.
interface control_fsm_if #(
  parameter int REG_ADDR_W = 5,
  parameter int ALUOP_W    = 3
);
  logic [31:0]           instr_in;
  logic                  instr_valid;
  logic                  instr_ready;
  logic                  ZeroFlag;
  logic [31:0]           instruction;
  logic [REG_ADDR_W-1:0] reg1_addr;
  logic [REG_ADDR_W-1:0] reg2_addr;
  logic [REG_ADDR_W-1:0] write_reg_addr;
  logic                  ctrl0;
  logic                  ctrl1;
  logic                  ctrl2;
  logic                  ctrl3;
  logic                  ctrl4;
  logic [ALUOP_W-1:0]    ALUOp;
  logic                  done;
  logic                  branch_taken;
  logic                  illegal_instr;
  modport master (
    output instr_in, instr_valid, ZeroFlag,
    input  instr_ready, instruction, reg1_addr, reg2_addr, write_reg_addr,
           ctrl0, ctrl1, ctrl2, ctrl3, ctrl4, ALUOp, done, branch_taken, illegal_instr
  );
  modport slave (
    input  instr_in, instr_valid, ZeroFlag,
    output instr_ready, instruction, reg1_addr, reg2_addr, write_reg_addr,
           ctrl0, ctrl1, ctrl2, ctrl3, ctrl4, ALUOp, done, branch_taken, illegal_instr
  );
endinterface

// File: rtl/alu_decoder.sv
// alu_decoder: {opcode, funct3, funct7} -> {ALU op, illegal}; branch opcode legal only with CTRL_BRANCH_EN.
module alu_decoder
  import ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  output alu_op_e    alu_op,
  output logic       illegal
);
  always_comb begin
    alu_op  = ALU_ADD;
    illegal = 1'b1;
    case (opcode)
      OP_R: begin
        alu_op  = (funct3 == 3'b000 && funct7 == 7'b0100000) ? ALU_SUB : f3_to_alu_op(funct3);
        illegal = funct3 == 3'b011 || (funct3 == 3'b101 && funct7 != 7'b0);
      end
      OP_IMM: begin
        alu_op  = f3_to_alu_op(funct3);
        illegal = funct3 == 3'b011;
      end
      OP_LOAD, OP_STORE: illegal = funct3 != 3'b010;
`ifdef CTRL_BRANCH_EN
      OP_BRANCH: begin
        alu_op  = ALU_SUB;
        illegal = funct3[2:1] != 2'b00;
      end
`endif
      default: illegal = 1'b1;
    endcase
  end
endmodule

// File: rtl/control_fsm.sv
// control_fsm: multi-cycle RV32I-subset controller sequencing datapath strobes; CTRL_BRANCH_EN enables beq/bne.
module control_fsm
  import ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int ALUOP_W    = 3
) (
  input logic         clk,
  input logic         reset,
  control_fsm_if.slave bus
);
  state_e                state_q, state_d;
  logic [31:0]           ir_q, ir_d;
  logic [4:0]            ctrl_q, ctrl_d;
  logic [ALUOP_W-1:0]    alu_op_q, alu_op_d;
  logic [REG_ADDR_W-1:0] rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
  logic                  ready_q, ready_d, done_q, done_d, taken_q, taken_d, illegal_q, illegal_d;
  alu_op_e               dec_op;
  logic                  dec_illegal;
  logic [6:0]            opcode;
  logic                  is_r, is_i, is_lw, is_sw, active, legal, in_mem, in_wb;
  alu_decoder u_dec (
    .opcode (ir_d[6:0]),
    .funct3 (ir_d[14:12]),
    .funct7 (ir_d[31:25]),
    .alu_op (dec_op),
    .illegal(dec_illegal)
  );
  assign opcode = ir_d[6:0];
  assign is_r   = opcode == OP_R;
  assign is_i   = opcode == OP_IMM;
  assign is_lw  = opcode == OP_LOAD;
  assign is_sw  = opcode == OP_STORE;
  // Outputs are registered from the next state and next IR, so they stay Moore while changing on the state edge.
  always_comb begin
    ir_d    = (state_q == S_IDLE && bus.instr_valid) ? bus.instr_in : ir_q;
    state_d = S_IDLE;
    case (state_q)
      S_IDLE:   state_d = bus.instr_valid ? S_DECODE : S_IDLE;
      S_DECODE: state_d = dec_illegal ? S_IDLE : S_EXEC;
      S_EXEC:   state_d = (is_lw || is_sw) ? S_MEM : S_WB;
      S_MEM:    state_d = is_lw ? S_WB : S_IDLE;
      default:  state_d = S_IDLE;
    endcase
    active    = state_d != S_IDLE;
    legal     = active && !dec_illegal;
    in_mem    = state_d == S_MEM;
    in_wb     = state_d == S_WB;
    ready_d   = !active;
    rs1_d     = active ? ir_d[15 +: REG_ADDR_W] : '0;
    rs2_d     = active ? ir_d[20 +: REG_ADDR_W] : '0;
    rd_d      = active ? ir_d[7 +: REG_ADDR_W] : '0;
    alu_op_d  = legal ? ALUOP_W'(dec_op) : '0;
    ctrl_d    = '0;
    ctrl_d[CTRL_REG_WRITE]  = in_wb && (is_r || is_i || is_lw) && ir_d[11:7] != 5'd0;
    ctrl_d[CTRL_ALU_SRC]    = legal && (is_i || is_lw || is_sw);
    ctrl_d[CTRL_IMM_EN]     = legal && (is_i || is_lw || is_sw);
    ctrl_d[CTRL_MEM_TO_REG] = (in_mem || in_wb) && is_lw;
    ctrl_d[CTRL_MEM_WRITE]  = in_mem && is_sw;
    done_d    = in_wb || (in_mem && is_sw);
    illegal_d = state_d == S_DECODE && dec_illegal;
`ifdef CTRL_BRANCH_EN
    // WB is only entered from EXEC for branches, so ZeroFlag here is its value at the end of EXEC.
    taken_d   = in_wb && opcode == OP_BRANCH && (ir_d[12] ? !bus.ZeroFlag : bus.ZeroFlag);
`else
    taken_d   = 1'b0;
`endif
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      ir_q      <= '0;
      ready_q   <= 1'b1;
      ctrl_q    <= '0;
      alu_op_q  <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      rd_q      <= '0;
      done_q    <= 1'b0;
      taken_q   <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      ready_q   <= ready_d;
      ctrl_q    <= ctrl_d;
      alu_op_q  <= alu_op_d;
      rs1_q     <= rs1_d;
      rs2_q     <= rs2_d;
      rd_q      <= rd_d;
      done_q    <= done_d;
      taken_q   <= taken_d;
      illegal_q <= illegal_d;
    end
  end
  assign bus.instr_ready    = ready_q;
  assign bus.instruction    = ir_q;
  assign bus.reg1_addr      = rs1_q;
  assign bus.reg2_addr      = rs2_q;
  assign bus.write_reg_addr = rd_q;
  assign bus.ctrl0          = ctrl_q[CTRL_REG_WRITE];
  assign bus.ctrl1          = ctrl_q[CTRL_ALU_SRC];
  assign bus.ctrl2          = ctrl_q[CTRL_IMM_EN];
  assign bus.ctrl3          = ctrl_q[CTRL_MEM_TO_REG];
  assign bus.ctrl4          = ctrl_q[CTRL_MEM_WRITE];
  assign bus.ALUOp          = alu_op_q;
  assign bus.done           = done_q;
  assign bus.branch_taken   = taken_q;
  assign bus.illegal_instr  = illegal_q;
endmodule

// File: tb/tb_control_fsm.sv
// tb_control_fsm: scoreboard bench for control_fsm; per-cycle expected output vectors queued at accept time.
module tb_control_fsm;
  typedef logic [26:0] vec_t;
  typedef struct {vec_t v; vec_t m;} exp_t;
  localparam vec_t ALL   = '1;
  localparam vec_t NO_OP = ~(27'h7 << 15);
  localparam vec_t IDLE  = {1'b1, 26'b0};
  logic clk = 1'b0;
  logic reset = 1'b1;
  exp_t sb[$];
  int n_cmp = 0;
  int n_err = 0;
  always #5 clk = ~clk;
  control_fsm_if bus();
  control_fsm dut (.clk(clk), .reset(reset), .bus(bus));
  function automatic vec_t mk(bit rdy, bit ill, bit dn, bit tk, logic [4:0] c, logic [2:0] op,
                              logic [4:0] a1, logic [4:0] a2, logic [4:0] wd);
    return {rdy, ill, dn, tk, c, op, a1, a2, wd};
  endfunction
  function automatic vec_t obs();
    return {bus.instr_ready, bus.illegal_instr, bus.done, bus.branch_taken,
            bus.ctrl4, bus.ctrl3, bus.ctrl2, bus.ctrl1, bus.ctrl0, bus.ALUOp,
            bus.reg1_addr, bus.reg2_addr, bus.write_reg_addr};
  endfunction
  task automatic push(vec_t v, vec_t m = ALL);
    sb.push_back('{v, m});
  endtask
  task automatic accept(logic [31:0] ins, logic zf);
    @(negedge clk);
    bus.instr_in = ins; bus.instr_valid = 1'b1; bus.ZeroFlag = zf;
    @(posedge clk);
    #1 bus.instr_valid = 1'b0; bus.instr_in = $urandom;
  endtask
  task automatic test_reset();
    reset = 1'b1; bus.instr_valid = 1'b1; bus.instr_in = 32'h00800913; bus.ZeroFlag = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (obs() !== IDLE) begin n_err++; $display("FAIL reset outputs: got %h want %h", obs(), IDLE); end
    n_cmp++;
    if (bus.instruction !== 32'h0) begin n_err++; $display("FAIL reset ir: got %h want 0", bus.instruction); end
    reset = 1'b0; bus.instr_valid = 1'b0;
  endtask
  task automatic test_addi();
    exp_t e; int j = 0;
    push(mk(0,0,0,0,5'b00110,3'd0,5'd0,5'd8,5'd18));
    push(mk(0,0,0,0,5'b00110,3'd0,5'd0,5'd8,5'd18));
    push(mk(0,0,1,0,5'b00111,3'd0,5'd0,5'd8,5'd18));
    push(IDLE);
    accept(32'h00800913, 1'b0);
    while (sb.size() != 0) begin
      @(negedge clk); e = sb.pop_front(); j++; n_cmp++;
      if (((obs() ^ e.v) & e.m) !== 0) begin n_err++; $display("FAIL addi k+%0d: got %h want %h", j, obs(), e.v); end
    end
    n_cmp++;
    if (bus.instruction !== 32'h00800913) begin n_err++; $display("FAIL addi ir: got %h want 00800913", bus.instruction); end
  endtask
  task automatic test_sw();
    exp_t e; int j = 0;
    push(mk(0,0,0,0,5'b00110,3'd0,5'd0,5'd18,5'd4));
    push(mk(0,0,0,0,5'b00110,3'd0,5'd0,5'd18,5'd4));
    push(mk(0,0,1,0,5'b10110,3'd0,5'd0,5'd18,5'd4));
    push(IDLE);
    accept(32'h01202223, 1'b0);
    while (sb.size() != 0) begin
      @(negedge clk); e = sb.pop_front(); j++; n_cmp++;
      if (((obs() ^ e.v) & e.m) !== 0) begin n_err++; $display("FAIL sw k+%0d: got %h want %h", j, obs(), e.v); end
    end
  endtask
  task automatic test_sub_and_rd0();
    exp_t e; int j = 0;
    push(mk(0,0,0,0,5'b00000,3'd1,5'd6,5'd7,5'd5));
    push(mk(0,0,0,0,5'b00000,3'd1,5'd6,5'd7,5'd5));
    push(mk(0,0,1,0,5'b00001,3'd1,5'd6,5'd7,5'd5));
    push(IDLE);
    accept(32'h407302B3, 1'b0);
    while (sb.size() != 0) begin
      @(negedge clk); e = sb.pop_front(); j++; n_cmp++;
      if (((obs() ^ e.v) & e.m) !== 0) begin n_err++; $display("FAIL sub k+%0d: got %h want %h", j, obs(), e.v); end
    end
    j = 0;
    push(mk(0,0,0,0,5'b00110,3'd0,5'd0,5'd0,5'd0));
    push(mk(0,0,0,0,5'b00110,3'd0,5'd0,5'd0,5'd0));
    push(mk(0,0,1,0,5'b00110,3'd0,5'd0,5'd0,5'd0));
    push(IDLE);
    accept(32'h00000013, 1'b0);
    while (sb.size() != 0) begin
      @(negedge clk); e = sb.pop_front(); j++; n_cmp++;
      if (((obs() ^ e.v) & e.m) !== 0) begin n_err++; $display("FAIL rd0 k+%0d: got %h want %h", j, obs(), e.v); end
    end
  endtask
  task automatic test_lw();
    exp_t e; int j = 0;
    push(mk(0,0,0,0,5'b00110,3'd0,5'd2,5'd0,5'd9));
    push(mk(0,0,0,0,5'b00110,3'd0,5'd2,5'd0,5'd9));
    push(mk(0,0,0,0,5'b01110,3'd0,5'd2,5'd0,5'd9));
    push(mk(0,0,1,0,5'b01111,3'd0,5'd2,5'd0,5'd9));
    push(IDLE);
    accept(32'h00012483, 1'b0);
    while (sb.size() != 0) begin
      @(negedge clk); e = sb.pop_front(); j++; n_cmp++;
      if (((obs() ^ e.v) & e.m) !== 0) begin n_err++; $display("FAIL lw k+%0d: got %h want %h", j, obs(), e.v); end
    end
  endtask
  task automatic test_branch();
    exp_t e; int j;
    logic [31:0] ins [3] = '{32'h00000463, 32'h00000463, 32'h00001463};
    logic        zf  [3] = '{1'b1, 1'b0, 1'b0};
    logic        tk  [3] = '{1'b1, 1'b0, 1'b1};
    for (int t = 0; t < 3; t++) begin
      j = 0;
`ifdef CTRL_BRANCH_EN
      push(mk(0,0,0,0,5'b00000,3'd1,5'd0,5'd0,5'd8));
      push(mk(0,0,0,0,5'b00000,3'd1,5'd0,5'd0,5'd8));
      push(mk(0,0,1,tk[t],5'b00000,3'd1,5'd0,5'd0,5'd8));
`else
      push(mk(0,1,0,0,5'b00000,3'd0,5'd0,5'd0,5'd8), NO_OP);
      push(IDLE);
`endif
      push(IDLE);
      accept(ins[t], zf[t]);
      while (sb.size() != 0) begin
        @(negedge clk); e = sb.pop_front(); j++; n_cmp++;
        if (((obs() ^ e.v) & e.m) !== 0) begin n_err++; $display("FAIL branch%0d k+%0d: got %h want %h", t, j, obs(), e.v); end
      end
    end
  endtask
  task automatic test_illegal();
    exp_t e; int j = 0;
    push(mk(0,1,0,0,5'b00000,3'd0,5'd31,5'd31,5'd31), NO_OP);
    push(IDLE);
    push(IDLE);
    accept(32'hFFFFFFFF, 1'b0);
    while (sb.size() != 0) begin
      @(negedge clk); e = sb.pop_front(); j++; n_cmp++;
      if (((obs() ^ e.v) & e.m) !== 0) begin n_err++; $display("FAIL illegal k+%0d: got %h want %h", j, obs(), e.v); end
    end
    j = 0;
    push(mk(0,1,0,0,5'b00000,3'd0,5'd6,5'd7,5'd5), NO_OP);
    push(IDLE);
    accept(32'h407352B3, 1'b0);
    while (sb.size() != 0) begin
      @(negedge clk); e = sb.pop_front(); j++; n_cmp++;
      if (((obs() ^ e.v) & e.m) !== 0) begin n_err++; $display("FAIL srl_f7 k+%0d: got %h want %h", j, obs(), e.v); end
    end
  endtask
  task automatic test_reset_mid_lw();
    exp_t e; int j = 0;
    push(mk(0,0,0,0,5'b00110,3'd0,5'd2,5'd0,5'd9));
    push(mk(0,0,0,0,5'b00110,3'd0,5'd2,5'd0,5'd9));
    push(mk(0,0,0,0,5'b01110,3'd0,5'd2,5'd0,5'd9));
    accept(32'h00012483, 1'b0);
    while (sb.size() != 0) begin
      @(negedge clk); e = sb.pop_front(); j++; n_cmp++;
      if (((obs() ^ e.v) & e.m) !== 0) begin n_err++; $display("FAIL lw_rst k+%0d: got %h want %h", j, obs(), e.v); end
    end
    reset = 1'b1;
    push(IDLE);
    @(negedge clk); e = sb.pop_front(); n_cmp++;
    if (obs() !== e.v) begin n_err++; $display("FAIL lw_rst after reset: got %h want %h", obs(), e.v); end
    n_cmp++;
    if (bus.instruction !== 32'h0) begin n_err++; $display("FAIL lw_rst ir: got %h want 0", bus.instruction); end
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); n_cmp++;
      if (obs() !== IDLE) begin n_err++; $display("FAIL lw_rst idle%0d: got %h want %h", k, obs(), IDLE); end
    end
  endtask
  task automatic test_back_to_back();
    exp_t e; int j = 0;
    push(mk(0,0,0,0,5'b00110,3'd0,5'd0,5'd8,5'd18));
    push(mk(0,0,0,0,5'b00110,3'd0,5'd0,5'd8,5'd18));
    push(mk(0,0,1,0,5'b00111,3'd0,5'd0,5'd8,5'd18));
    push(IDLE);
    push(mk(0,0,0,0,5'b00000,3'd1,5'd6,5'd7,5'd5));
    push(mk(0,0,0,0,5'b00000,3'd1,5'd6,5'd7,5'd5));
    push(mk(0,0,1,0,5'b00001,3'd1,5'd6,5'd7,5'd5));
    push(IDLE);
    @(negedge clk);
    bus.instr_in = 32'h00800913; bus.instr_valid = 1'b1;
    @(posedge clk);
    while (sb.size() != 0) begin
      @(negedge clk); e = sb.pop_front(); j++; n_cmp++;
      if (((obs() ^ e.v) & e.m) !== 0) begin n_err++; $display("FAIL b2b k+%0d: got %h want %h", j, obs(), e.v); end
      if (j == 1) bus.instr_in = 32'h407302B3;
      if (j == 3) begin
        n_cmp++;
        if (bus.instruction !== 32'h00800913) begin n_err++; $display("FAIL b2b ir held: got %h want 00800913", bus.instruction); end
      end
      if (j == 5) bus.instr_valid = 1'b0;
    end
  endtask
  initial begin
    bus.instr_in = '0; bus.instr_valid = 1'b0; bus.ZeroFlag = 1'b0;
    test_reset();
    test_addi();
    test_sw();
    test_sub_and_rd0();
    test_lw();
    test_branch();
    test_illegal();
    test_reset_mid_lw();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
